// File: rtl/rv32i_types.sv
// Shared rv32i core types: register index, opcodes, control word and the
// hazard controller's accounting state.
package rv32i_types;

  typedef logic [4:0] rv32i_reg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    rv32i_opcode opcode;
    logic        load_regfile;
  } rv32i_control_word;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IWAIT = 2'd1,
    DWAIT = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Cache handshake bundle seen by the hazard controller.
// A request (icache_read / dcache_req) stays high until its single-cycle resp
// pulse; every cycle with request high and resp low is a miss cycle.
interface hazard_ctrl_if;
  logic icache_read;
  logic icache_resp;
  logic dcache_req;
  logic dcache_resp;

  modport ctrl  (input  icache_read, icache_resp, dcache_req, dcache_resp);
  modport cache (output icache_read, icache_resp, dcache_req, dcache_resp);
endinterface

// File: rtl/hazard_perf_counters.sv
// Free-running 32-bit performance counters for pipeline stalls, load-use
// bubbles and branch flushes; all wrap modulo 2^32.
module hazard_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        lu,
  input  logic        br_taken,
  output logic [31:0] stall_cycles,
  output logic [31:0] lu_count,
  output logic [31:0] flush_count
);

  logic [31:0] stall_q, stall_d;
  logic [31:0] lu_q, lu_d;
  logic [31:0] flush_q, flush_d;
  logic        stall_en, lu_en, flush_en;

  // A load-use swallowed by a branch flush, or one hidden under a freeze,
  // never produces its own bubble.
  always_comb begin
    stall_en = freeze | (lu & ~br_taken);
    lu_en    = lu & ~freeze & ~br_taken;
    flush_en = br_taken & ~freeze;
    stall_d  = stall_q + {31'd0, stall_en};
    lu_d     = lu_q + {31'd0, lu_en};
    flush_d  = flush_q + {31'd0, flush_en};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      lu_q    <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      lu_q    <= lu_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign lu_count     = lu_q;
  assign flush_count  = flush_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: combinational stall/flush decisions from
// cache misses, EX load-use hazards and EX redirects, plus a miss watchdog.
module hazard_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  rv32i_reg          ID_rs1_num,
  input  rv32i_reg          ID_rs2_num,
  input  rv32i_control_word ID_ctrlword,
  input  rv32i_reg          EX_rd_num,
  input  rv32i_control_word EX_ctrlword,
  input  logic              EX_br_taken,
  hazard_ctrl_if.ctrl       cache_if,
  output logic              stall_pc,
  output logic              stall_IF_ID,
  output logic              stall_ID_EX,
  output logic              stall_EX_MEM,
  output logic              stall_MEM_WB,
  output logic              flush_IF_ID,
  output logic              flush_ID_EX,
  output logic              hang_err,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       lu_count,
  output logic [31:0]       flush_count,
  output state_t            state
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT - 1);

  logic imiss, dmiss, freeze, lu;
  logic id_uses_rs1, id_uses_rs2;
  logic kind_change;
  state_t state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic hang_q, hang_d;
  logic unused_id_load_regfile;

  assign unused_id_load_regfile = ID_ctrlword.load_regfile;

  always_comb begin
    imiss = cache_if.icache_read & ~cache_if.icache_resp;
    dmiss = cache_if.dcache_req & ~cache_if.dcache_resp;
    freeze = imiss | dmiss;

    id_uses_rs1 = !(ID_ctrlword.opcode inside {op_lui, op_auipc, op_jal});
    id_uses_rs2 = ID_ctrlword.opcode inside {op_reg, op_br, op_store};
    lu = (EX_ctrlword.opcode == op_load) && EX_ctrlword.load_regfile &&
         (EX_rd_num != 5'd0) &&
         ((id_uses_rs1 && (EX_rd_num == ID_rs1_num)) ||
          (id_uses_rs2 && (EX_rd_num == ID_rs2_num)));
  end

  // Priority: reset, freeze, redirect, load-use bubble.
  always_comb begin
    stall_pc     = 1'b0;
    stall_IF_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    stall_EX_MEM = 1'b0;
    stall_MEM_WB = 1'b0;
    flush_IF_ID  = 1'b0;
    flush_ID_EX  = 1'b0;
    if (rst) begin
      flush_IF_ID = 1'b1;
      flush_ID_EX = 1'b1;
    end else if (freeze) begin
      stall_pc     = 1'b1;
      stall_IF_ID  = 1'b1;
      stall_ID_EX  = 1'b1;
      stall_EX_MEM = 1'b1;
      stall_MEM_WB = 1'b1;
    end else if (EX_br_taken) begin
      flush_IF_ID = 1'b1;
      flush_ID_EX = 1'b1;
    end else if (lu) begin
      stall_pc    = 1'b1;
      stall_IF_ID = 1'b1;
      flush_ID_EX = 1'b1;
    end
  end

  always_comb begin
    state_d = RUN;
    if (dmiss)      state_d = DWAIT;
    else if (imiss) state_d = IWAIT;

    kind_change = ((state_q == IWAIT) && (state_d == DWAIT)) ||
                  ((state_q == DWAIT) && (state_d == IWAIT));

    wait_d = wait_q;
    if (!freeze || kind_change) wait_d = '0;
    else if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;

    hang_d = hang_q;
    if (freeze && !kind_change && (wait_q == WAIT_MAX)) hang_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      hang_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      hang_q  <= hang_d;
    end
  end

  assign state    = state_q;
  assign hang_err = hang_q;

  hazard_perf_counters u_perf (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .lu           (lu),
    .br_taken     (EX_br_taken),
    .stall_cycles (stall_cycles),
    .lu_count     (lu_count),
    .flush_count  (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with TIMEOUT = 8.
module tb_hazard_ctrl;
  import rv32i_types::*;

  localparam logic [6:0] CTL_NONE   = 7'b0000000;
  localparam logic [6:0] CTL_FLUSH  = 7'b0000011;
  localparam logic [6:0] CTL_FREEZE = 7'b1111100;
  localparam logic [6:0] CTL_LU     = 7'b1100001;

  logic clk = 1'b0;
  logic rst;
  rv32i_reg id_rs1, id_rs2, ex_rd;
  rv32i_control_word id_cw, ex_cw;
  logic ex_br;
  logic s_pc, s_ifid, s_idex, s_exmem, s_memwb, f_ifid, f_idex;
  logic hang;
  logic [31:0] stall_cycles, lu_count, flush_count;
  state_t state;
  logic [6:0] ctl;

  int n_run = 0;
  int n_fail = 0;
  logic [31:0] exp_stall = 0;
  logic [31:0] exp_lu = 0;
  logic [31:0] exp_flush = 0;

  hazard_ctrl_if cif ();

  hazard_ctrl #(.TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .ID_rs1_num   (id_rs1),
    .ID_rs2_num   (id_rs2),
    .ID_ctrlword  (id_cw),
    .EX_rd_num    (ex_rd),
    .EX_ctrlword  (ex_cw),
    .EX_br_taken  (ex_br),
    .cache_if     (cif),
    .stall_pc     (s_pc),
    .stall_IF_ID  (s_ifid),
    .stall_ID_EX  (s_idex),
    .stall_EX_MEM (s_exmem),
    .stall_MEM_WB (s_memwb),
    .flush_IF_ID  (f_ifid),
    .flush_ID_EX  (f_idex),
    .hang_err     (hang),
    .stall_cycles (stall_cycles),
    .lu_count     (lu_count),
    .flush_count  (flush_count),
    .state        (state)
  );

  assign ctl = {s_pc, s_ifid, s_idex, s_exmem, s_memwb, f_ifid, f_idex};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_idle();
    id_cw.opcode = op_imm; id_cw.load_regfile = 1'b1;
    ex_cw.opcode = op_reg; ex_cw.load_regfile = 1'b1;
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; ex_br = 1'b0;
    cif.icache_read = 1'b0; cif.icache_resp = 1'b0;
    cif.dcache_req = 1'b0; cif.dcache_resp = 1'b0;
  endtask

  task automatic drv_ex(input rv32i_opcode op, input logic ld, input rv32i_reg rd);
    ex_cw.opcode = op; ex_cw.load_regfile = ld; ex_rd = rd;
  endtask

  task automatic drv_id(input rv32i_opcode op, input rv32i_reg rs1, input rv32i_reg rs2);
    id_cw.opcode = op; id_rs1 = rs1; id_rs2 = rs2;
  endtask

  task automatic test_reset();
    drv_idle();
    rst = 1'b1;
    #1;
    n_run++;
    if (ctl !== CTL_FLUSH) begin
      n_fail++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_FLUSH);
    end
    step();
    step();
    rst = 1'b0;
    n_run++;
    if (state !== RUN || hang !== 1'b0) begin
      n_fail++; $display("FAIL reset_state got=%0d/%b exp=RUN/0", state, hang);
    end
    n_run++;
    if ({stall_cycles, lu_count, flush_count} !== 96'd0) begin
      n_fail++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", stall_cycles, lu_count, flush_count);
    end
    #1;
    n_run++;
    if (ctl !== CTL_NONE) begin
      n_fail++; $display("FAIL idle_ctl got=%b exp=%b", ctl, CTL_NONE);
    end
  endtask

  task automatic test_load_use();
    // lw x5 in EX, add x6,x5,x1 in ID
    drv_ex(op_load, 1'b1, 5'd5);
    drv_id(op_reg, 5'd5, 5'd1);
    #1;
    n_run++;
    if (ctl !== CTL_LU) begin
      n_fail++; $display("FAIL lu_add got=%b exp=%b", ctl, CTL_LU);
    end
    step();
    exp_stall = exp_stall + 1; exp_lu = exp_lu + 1;
    drv_ex(op_reg, 1'b1, 5'd5);
    #1;
    n_run++;
    if (ctl !== CTL_NONE) begin
      n_fail++; $display("FAIL lu_one_bubble got=%b exp=%b", ctl, CTL_NONE);
    end
    n_run++;
    if (lu_count !== exp_lu) begin
      n_fail++; $display("FAIL lu_count got=%0d exp=%0d", lu_count, exp_lu);
    end
    drv_ex(op_load, 1'b1, 5'd0);
    drv_id(op_reg, 5'd0, 5'd0);
    #1;
    n_run++;
    if (ctl !== CTL_NONE) begin
      n_fail++; $display("FAIL lu_rd0 got=%b exp=%b", ctl, CTL_NONE);
    end
    step();
    drv_ex(op_load, 1'b1, 5'd5);
    drv_id(op_imm, 5'd2, 5'd5);
    #1;
    n_run++;
    if (ctl !== CTL_NONE) begin
      n_fail++; $display("FAIL lu_imm_rs2 got=%b exp=%b", ctl, CTL_NONE);
    end
    step();
    drv_id(op_store, 5'd3, 5'd5);
    #1;
    n_run++;
    if (ctl !== CTL_LU) begin
      n_fail++; $display("FAIL lu_store_rs2 got=%b exp=%b", ctl, CTL_LU);
    end
    step();
    exp_stall = exp_stall + 1; exp_lu = exp_lu + 1;
    drv_idle();
    n_run++;
    if (lu_count !== exp_lu || stall_cycles !== exp_stall) begin
      n_fail++; $display("FAIL lu_totals got=%0d/%0d exp=%0d/%0d", lu_count, stall_cycles, exp_lu, exp_stall);
    end
  endtask

  task automatic test_dcache_miss();
    for (int i = 0; i < 5; i++) begin
      cif.dcache_req = 1'b1;
      #1;
      n_run++;
      if (ctl !== CTL_FREEZE) begin
        n_fail++; $display("FAIL dmiss_ctl cyc=%0d got=%b exp=%b", i, ctl, CTL_FREEZE);
      end
      step();
      n_run++;
      if (state !== DWAIT) begin
        n_fail++; $display("FAIL dmiss_state cyc=%0d got=%0d exp=%0d", i, state, DWAIT);
      end
    end
    cif.dcache_resp = 1'b1;
    #1;
    n_run++;
    if (ctl !== CTL_NONE) begin
      n_fail++; $display("FAIL dmiss_resp_ctl got=%b exp=%b", ctl, CTL_NONE);
    end
    step();
    drv_idle();
    exp_stall = exp_stall + 5;
    n_run++;
    if (state !== RUN || stall_cycles !== exp_stall) begin
      n_fail++; $display("FAIL dmiss_done got=%0d/%0d exp=RUN/%0d", state, stall_cycles, exp_stall);
    end
  endtask

  task automatic test_branch_freeze();
    ex_br = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cif.icache_read = 1'b1;
      #1;
      n_run++;
      if (ctl !== CTL_FREEZE) begin
        n_fail++; $display("FAIL brfrz_ctl cyc=%0d got=%b exp=%b", i, ctl, CTL_FREEZE);
      end
      step();
    end
    exp_stall = exp_stall + 3;
    n_run++;
    if (state !== IWAIT || flush_count !== exp_flush) begin
      n_fail++; $display("FAIL brfrz_mid got=%0d/%0d exp=IWAIT/%0d", state, flush_count, exp_flush);
    end
    cif.icache_resp = 1'b1;
    #1;
    n_run++;
    if (ctl !== CTL_FLUSH) begin
      n_fail++; $display("FAIL brfrz_flush got=%b exp=%b", ctl, CTL_FLUSH);
    end
    step();
    drv_idle();
    exp_flush = exp_flush + 1;
    #1;
    n_run++;
    if (ctl !== CTL_NONE || flush_count !== exp_flush || stall_cycles !== exp_stall) begin
      n_fail++; $display("FAIL brfrz_after got=%b/%0d/%0d exp=%b/%0d/%0d", ctl, flush_count, stall_cycles, CTL_NONE, exp_flush, exp_stall);
    end
  endtask

  task automatic test_branch_lu();
    drv_ex(op_load, 1'b1, 5'd7);
    drv_id(op_reg, 5'd7, 5'd2);
    ex_br = 1'b1;
    #1;
    n_run++;
    if (ctl !== CTL_FLUSH) begin
      n_fail++; $display("FAIL brlu_ctl got=%b exp=%b", ctl, CTL_FLUSH);
    end
    step();
    drv_idle();
    exp_flush = exp_flush + 1;
    n_run++;
    if (lu_count !== exp_lu || flush_count !== exp_flush || stall_cycles !== exp_stall) begin
      n_fail++; $display("FAIL brlu_counts got=%0d/%0d/%0d exp=%0d/%0d/%0d", lu_count, flush_count, stall_cycles, exp_lu, exp_flush, exp_stall);
    end
  endtask

  task automatic test_watchdog();
    cif.dcache_req = 1'b1;
    for (int i = 0; i < 7; i++) step();
    n_run++;
    if (hang !== 1'b0) begin
      n_fail++; $display("FAIL wdog_early got=%b exp=0", hang);
    end
    step();
    n_run++;
    if (hang !== 1'b1) begin
      n_fail++; $display("FAIL wdog_set got=%b exp=1", hang);
    end
    cif.dcache_resp = 1'b1;
    step();
    drv_idle();
    step();
    exp_stall = exp_stall + 8;
    n_run++;
    if (hang !== 1'b1 || stall_cycles !== exp_stall) begin
      n_fail++; $display("FAIL wdog_sticky got=%b/%0d exp=1/%0d", hang, stall_cycles, exp_stall);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_stall = 0; exp_lu = 0; exp_flush = 0;
    n_run++;
    if (hang !== 1'b0 || {stall_cycles, lu_count, flush_count} !== 96'd0) begin
      n_fail++; $display("FAIL wdog_rst got=%b/%0d/%0d/%0d exp=0/0/0/0", hang, stall_cycles, lu_count, flush_count);
    end
  endtask

  task automatic test_reset_mid_miss();
    cif.icache_read = 1'b1;
    step();
    step();
    n_run++;
    if (state !== IWAIT || stall_cycles !== 32'd2) begin
      n_fail++; $display("FAIL rmm_pre got=%0d/%0d exp=IWAIT/2", state, stall_cycles);
    end
    rst = 1'b1;
    #1;
    n_run++;
    if (ctl !== CTL_FLUSH) begin
      n_fail++; $display("FAIL rmm_ctl got=%b exp=%b", ctl, CTL_FLUSH);
    end
    step();
    rst = 1'b0;
    n_run++;
    if (state !== RUN || stall_cycles !== 32'd0 || hang !== 1'b0) begin
      n_fail++; $display("FAIL rmm_post got=%0d/%0d/%b exp=RUN/0/0", state, stall_cycles, hang);
    end
    // A cleared wait counter needs a full 8 fresh miss cycles to trip
    for (int i = 0; i < 7; i++) step();
    n_run++;
    if (hang !== 1'b0) begin
      n_fail++; $display("FAIL rmm_wait_clr got=%b exp=0", hang);
    end
    step();
    n_run++;
    if (hang !== 1'b1 || stall_cycles !== 32'd8) begin
      n_fail++; $display("FAIL rmm_wdog got=%b/%0d exp=1/8", hang, stall_cycles);
    end
    drv_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drv_idle();
    test_reset();
    test_load_use();
    test_dcache_miss();
    test_branch_freeze();
    test_branch_lu();
    test_watchdog();
    test_reset_mid_miss();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage rv32i core. Each cycle it decides which pipeline registers hold, which receive a bubble, and which are flushed. Inputs are the cache handshakes, load-use hazards between ID and EX, and taken branches/jumps resolved in EX. It also keeps a cache-hang watchdog and 32-bit performance counters. It sits beside the MEM→EX and WB→EX forwarding units and covers the one hazard they cannot: a load in EX whose result is needed by the instruction in ID.

## Interface
- `TIMEOUT`, default 1024: consecutive miss cycles before `hang_err` sets; minimum 2.
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `ID_rs1_num`, `ID_rs2_num` in `rv32i_reg`: source registers of the instruction in ID.
- `ID_ctrlword` in `rv32i_control_word`: ID control word; uses `opcode`.
- `EX_rd_num` in `rv32i_reg`: destination register of the instruction in EX.
- `EX_ctrlword` in `rv32i_control_word`: EX control word; uses `opcode`, `load_regfile`.
- `EX_br_taken` in 1: EX redirects the PC (taken branch, jal, jalr).
- `icache_read`, `icache_resp` in 1: fetch request / done.
- `dcache_req`, `dcache_resp` in 1: MEM read-or-write request / done.
- `stall_pc`, `stall_IF_ID`, `stall_ID_EX`, `stall_EX_MEM`, `stall_MEM_WB` out 1: hold the register.
- `flush_IF_ID`, `flush_ID_EX` out 1: load a nop on the next edge.
- `hang_err` out 1: sticky watchdog flag.
- `stall_cycles`, `lu_count`, `flush_count` out 32: performance counters.

## Operation
- `imiss = icache_read & ~icache_resp`; `dmiss = dcache_req & ~dcache_resp`; `freeze = imiss | dmiss`.
- Load-use (`lu`) fires when all of these hold:
  - `EX_ctrlword.opcode == op_load` and `EX_ctrlword.load_regfile`;
  - `EX_rd_num != 0`;
  - it matches either `ID_rs1_num`, when ID uses rs1 (opcode not op_lui, op_auipc, op_jal), or `ID_rs2_num`, when ID uses rs2 (opcode is op_reg, op_br or op_store).
- Output priority, highest first:
  1. `rst`: both flushes = 1, all stalls = 0.
  2. `freeze`: all five stalls = 1 and both flushes = 0. The whole pipe holds, including an EX branch; the redirect is applied once unfrozen.
  3. `EX_br_taken`: `flush_IF_ID = flush_ID_EX = 1`, stalls 0. A simultaneous `lu` is discarded because the ID instruction is wrong-path.
  4. `lu`: `stall_pc = stall_IF_ID = 1`, `flush_ID_EX = 1`, the rest 0. This gives exactly one bubble; the load then reaches MEM and the consumer takes WB forwarding.
  5. Otherwise all outputs are 0.
- FSM (`state_t`, registered):
  - States: RUN, IWAIT, DWAIT.
  - Any state moves to DWAIT when `dmiss`, to IWAIT when `imiss & ~dmiss`, and to RUN otherwise.
  - The state exists for accounting and the watchdog only; the outputs above stay combinational.
- Watchdog:
  - `wait_cnt` increments every cycle `freeze` = 1 and clears to 0 when `freeze` = 0 or the miss kind changes (IWAIT↔DWAIT).
  - When `wait_cnt` reaches `TIMEOUT-1` while `freeze` = 1, `hang_err` sets on that edge and stays 1 until `rst`.
  - `wait_cnt` saturates at `TIMEOUT-1`.
- Counters (wrap modulo 2^32):
  - `stall_cycles` increments once per cycle in which `freeze | (lu & ~EX_br_taken)`.
  - `lu_count` increments per cycle with `lu & ~freeze & ~EX_br_taken`.
  - `flush_count` increments per cycle with `EX_br_taken & ~freeze`.

## Timing
- Stall and flush outputs are combinational from the current-cycle inputs, with zero latency. They take effect on the same rising edge.
- Counters, `hang_err` and `state` are registered and update one edge after the qualifying cycle.
- Reset values: state RUN, `wait_cnt` 0, `hang_err` 0, all counters 0. Combinational outputs are as in priority 1 while `rst` is high.
- Reset during a miss: the FSM returns to RUN and `wait_cnt` clears. The caches are reset by the same `rst` and are not tracked further.
- `icache_resp` and `dcache_resp` are single-cycle pulses. A response cycle is not a miss cycle, so the pipe advances on that edge.
- A simultaneous imiss and dmiss counts as one stall cycle, and the FSM goes to DWAIT.

## Structure
- Add `state_t` (RUN, IWAIT, DWAIT) to `rv32i_types`. Everything else uses the existing `rv32i_reg`, `rv32i_control_word` and opcode enums.
- Sub-module `hazard_perf_counters` holds the three 32-bit counters and their enables. The FSM, watchdog and priority logic stay in `hazard_ctrl`.

## Test plan
- **Load-use:** lw x5 in EX, add x6,x5,x1 in ID, no misses. Require `stall_pc = stall_IF_ID = flush_ID_EX = 1` for exactly one cycle and `lu_count` 0→1. Repeat with `EX_rd_num` = 0, or ID opcode op_imm matching only rs2: no stall.
- **Dcache miss:** `dcache_req` high, `dcache_resp` arrives after 5 cycles. Require all stalls = 1 for 5 cycles, state DWAIT, 0 on the resp cycle, and `stall_cycles` = 5.
- **Branch during freeze:** `EX_br_taken` = 1 during a 3-cycle imiss. Require no flush during the miss, then one flush cycle with `flush_IF_ID = flush_ID_EX = 1` and `flush_count` = 1.
- **Branch with load-use:** `EX_br_taken` and `lu` in the same cycle. Require flushes only, stalls 0 and `lu_count` unchanged.
- **Watchdog:** with `TIMEOUT` = 8, hold `dcache_req` with no resp. Require `hang_err` = 1 after the 8th miss cycle, still 1 after the resp arrives, and 0 after `rst`.
- **Reset mid-miss:** assert `rst` on cycle 3 of an imiss. Require state RUN, counters 0, `hang_err` 0, and flushes = 1 while `rst` is high.
